// File: rtl/boot_rom_port.sv
// boot_rom_port: CPU-side load port in front of the 512x32 synchronous boot ROM.
// Accepts byte/half/word loads inside a 2 KiB window, reads the ROM, and
// returns the little-endian lane with sign or zero extension. Writes,
// misaligned accesses, illegal sizes and out-of-window addresses get an
// error response without touching the ROM.
//
// Optional feature: define BOOT_ROM_PORT_PREFETCH_EN to add a one-word
// prefetch buffer that fetches the next sequential word after every load,
// so a sequential fetch that hits the buffer is answered in one cycle.
//
// Handshake: the master raises i_req and holds it (with stable attributes)
// until it sees o_ack; o_ack is a single-cycle strobe that qualifies o_data
// and o_err, which otherwise hold their last response value. The port does
// not look at i_req while responding, and a request still high when the port
// is back in IDLE is taken as a new request.
module boot_rom_port #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data,
  output logic        o_ack,
  output logic        o_err,
  output logic [8:0]  o_rom_addr,
  input  logic [31:0] i_rom_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ROM_RD  = 3'd1,
    S_ROM_CAP = 3'd2,
    S_RESP    = 3'd3,
    S_PF_RD   = 3'd4,
    S_PF_CAP  = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_data;
  logic        r_ack;
  logic        r_err;
  logic [8:0]  r_rom_addr;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_uns;

`ifdef BOOT_ROM_PORT_PREFETCH_EN
  logic [31:0] r_pf_data;
  logic [8:0]  r_pf_tag;
  logic        r_pf_valid;
  logic [8:0]  r_pf_next;
  logic        r_pf_go;
  logic        w_hit;
`endif

  logic        w_err;

  // Select the addressed lane and extend it to 32 bits.
  function automatic logic [31:0] f_extract(input logic [31:0] word,
                                            input logic [1:0]  off,
                                            input logic [1:0]  size,
                                            input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Classify the incoming request as illegal (answered with an error).
  always_comb begin
    w_err = i_we
          | (i_size == 2'd3)
          | (i_addr[31:11] != ADDR_BASE[31:11])
          | ((i_size == 2'd1) & i_addr[0])
          | ((i_size == 2'd2) & (i_addr[1:0] != 2'b00));
  end

`ifdef BOOT_ROM_PORT_PREFETCH_EN
  // Buffer hit: legal word index matches the valid prefetched tag.
  always_comb begin
    w_hit = r_pf_valid & (r_pf_tag == i_addr[10:2]);
  end
`endif

  // Control FSM with registered response and ROM address outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_data     <= 32'h0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rom_addr <= 9'h0;
      r_off      <= 2'b00;
      r_size     <= 2'b00;
      r_uns      <= 1'b0;
`ifdef BOOT_ROM_PORT_PREFETCH_EN
      r_pf_data  <= 32'h0;
      r_pf_tag   <= 9'h0;
      r_pf_valid <= 1'b0;
      r_pf_next  <= 9'h0;
      r_pf_go    <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_off  <= i_addr[1:0];
            r_size <= i_size;
            r_uns  <= i_unsigned;
            if (w_err) begin
              // Errors never reach the ROM or the prefetch buffer.
              r_data  <= 32'h0;
              r_err   <= 1'b1;
              r_ack   <= 1'b1;
              r_state <= S_RESP;
`ifdef BOOT_ROM_PORT_PREFETCH_EN
              r_pf_go <= 1'b0;
            end else if (w_hit) begin
              r_data    <= f_extract(r_pf_data, i_addr[1:0], i_size, i_unsigned);
              r_err     <= 1'b0;
              r_ack     <= 1'b1;
              r_pf_next <= i_addr[10:2] + 9'd1;
              r_pf_go   <= 1'b1;
              r_state   <= S_RESP;
`endif
            end else begin
              r_rom_addr <= i_addr[10:2];
`ifdef BOOT_ROM_PORT_PREFETCH_EN
              r_pf_next  <= i_addr[10:2] + 9'd1;
              r_pf_go    <= 1'b1;
`endif
              r_state    <= S_ROM_RD;
            end
          end
        end
        S_ROM_RD: begin
          r_state <= S_ROM_CAP;
        end
        S_ROM_CAP: begin
          r_data  <= f_extract(i_rom_data, r_off, r_size, r_uns);
          r_err   <= 1'b0;
          r_ack   <= 1'b1;
          r_state <= S_RESP;
        end
        S_RESP: begin
`ifdef BOOT_ROM_PORT_PREFETCH_EN
          if (r_pf_go) begin
            // 9-bit increment wraps word 511 to word 0.
            r_rom_addr <= r_pf_next;
            r_pf_go    <= 1'b0;
            r_state    <= S_PF_RD;
          end else begin
            r_state <= S_IDLE;
          end
`else
          r_state <= S_IDLE;
`endif
        end
`ifdef BOOT_ROM_PORT_PREFETCH_EN
        S_PF_RD: begin
          r_state <= S_PF_CAP;
        end
        S_PF_CAP: begin
          r_pf_data  <= i_rom_data;
          r_pf_tag   <= r_rom_addr;
          r_pf_valid <= 1'b1;
          r_state    <= S_IDLE;
        end
`endif
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_data     = r_data;
  assign o_ack      = r_ack;
  assign o_err      = r_err;
  assign o_rom_addr = r_rom_addr;

endmodule
